// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised single-issue core with prioritised interrupts
// and a mem_ready load-stall handshake.
// Ports: clock/reset (sync, active-high); instr/pc to instruction ROM;
// mem_* data bus (mem_r_en held until mem_ready); int_req/int_mask/int_vec
// in, int_ack/in_isr/epc out.
module cpu_core_p #(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 8,
    parameter int N_IRQ      = 4,
    parameter int VEC_STRIDE = 4,
    parameter int RESET_PC   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        instr,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              mem_w_en,
    output logic              mem_r_en,
    input  logic [DATA_W-1:0] mem_r_data,
    input  logic              mem_ready,
    input  logic [N_IRQ-1:0]  int_req,
    input  logic [N_IRQ-1:0]  int_mask,
    input  logic [PC_W-1:0]   int_vec,
    output logic [N_IRQ-1:0]  int_ack,
    output logic              in_isr,
    output logic [PC_W-1:0]   epc
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic S_RUN  = 1'b0;
    localparam logic S_WAIT = 1'b1;

    logic [3:0][DATA_W-1:0] r_q, r_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [PC_W-1:0]        epc_q, epc_d;
    logic                   flag_q, flag_d;
    logic                   in_isr_q, in_isr_d;
    logic                   state_q, state_d;
    logic [1:0]             ld_rd_q, ld_rd_d;

    logic [3:0]        op;
    logic [1:0]        rd, rs;
    logic [3:0]        imm;
    logic [DATA_W-1:0] a, b;
    logic [SH_W-1:0]   sh;
    logic [PC_W-1:0]   pc_inc;
    logic [N_IRQ-1:0]  pend;
    logic [2:0]        irq_idx;
    logic              take;
    logic              we, re;
    logic [N_IRQ-1:0]  ack;

    always_comb begin
        op     = instr[7:4];
        rd     = instr[3:2];
        rs     = instr[1:0];
        imm    = instr[3:0];
        a      = r_q[rd];
        b      = r_q[rs];
        sh     = b[SH_W-1:0];
        pc_inc = pc_q + PC_W'(1);

        // Lowest-index pending line wins.
        pend    = int_req & int_mask;
        irq_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) irq_idx = 3'(i);
        end
        take = (state_q == S_RUN) && !in_isr_q && (|pend);

        r_d      = r_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        flag_d   = flag_q;
        in_isr_d = in_isr_q;
        state_d  = state_q;
        ld_rd_d  = ld_rd_q;
        we       = 1'b0;
        re       = 1'b0;
        ack      = '0;

        if (take) begin
            // Instruction at pc is dropped and re-fetched after reti.
            epc_d    = pc_q;
            pc_d     = int_vec + PC_W'(VEC_STRIDE * int'(irq_idx));
            in_isr_d = 1'b1;
            ack      = N_IRQ'(1) << irq_idx;
        end else if (state_q == S_WAIT) begin
            re = 1'b1;
            if (mem_ready) begin
                r_d[ld_rd_q] = mem_r_data;
                pc_d         = pc_inc;
                state_d      = S_RUN;
            end
        end else begin
            pc_d = pc_inc;
            unique case (op)
                4'h0: r_d[rd] = b;
                4'h1: r_d[rd] = a + b;
                4'h2: r_d[rd] = a - b;
                4'h3: r_d[rd] = a & b;
                4'h4: r_d[rd] = a | b;
                4'h5: r_d[rd] = ~b;
                4'h6: r_d[rd] = a << sh;
                4'h7: r_d[rd] = a >> sh;
                4'h8: r_d[rd] = $unsigned($signed(a) >>> sh);
                4'h9: flag_d = (a == b);
                4'hA: begin
                    if (flag_q) pc_d = PC_W'(b);
                    flag_d = 1'b0;
                end
                4'hB: begin
                    if (rd == 2'b11) begin
                        pc_d     = epc_q;
                        in_isr_d = 1'b0;
                    end else begin
                        pc_d = PC_W'(b);
                    end
                end
                4'hC: r_d[3][7:4] = imm;
                4'hD: r_d[3][3:0] = imm;
                4'hE: begin
                    re = 1'b1;
                    if (mem_ready) begin
                        r_d[rd] = mem_r_data;
                    end else begin
                        pc_d    = pc_q;
                        state_d = S_WAIT;
                        ld_rd_d = rd;
                    end
                end
                4'hF: we = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q      <= '0;
            pc_q     <= PC_W'(RESET_PC);
            epc_q    <= '0;
            flag_q   <= 1'b0;
            in_isr_q <= 1'b0;
            state_q  <= S_RUN;
            ld_rd_q  <= '0;
        end else begin
            r_q      <= r_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            flag_q   <= flag_d;
            in_isr_q <= in_isr_d;
            state_q  <= state_d;
            ld_rd_q  <= ld_rd_d;
        end
    end

    // Strobes are forced low while reset is held.
    assign mem_w_en   = we & ~reset;
    assign mem_r_en   = re & ~reset;
    assign int_ack    = reset ? '0 : ack;
    assign mem_addr   = b;
    assign mem_w_data = a;
    assign pc         = pc_q;
    assign epc        = epc_q;
    assign in_isr     = in_isr_q;

endmodule

// File: tb/tb_cpu_core_p.sv
// tb_cpu_core_p: randomized and directed checks of cpu_core_p
// (DATA_W=16, PC_W=8) against an instruction-level reference model.
module tb_cpu_core_p;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  instr = '0;
    logic [7:0]  pc;
    logic [15:0] mem_addr, mem_w_data;
    logic        mem_w_en, mem_r_en;
    logic [15:0] mem_r_data = '0;
    logic        mem_ready = 1'b1;
    logic [3:0]  int_req = '0;
    logic [3:0]  int_mask = '0;
    logic [7:0]  int_vec = '0;
    logic [3:0]  int_ack;
    logic        in_isr;
    logic [7:0]  epc;

    always #5 clock = ~clock;

    cpu_core_p #(
        .DATA_W(16), .PC_W(8), .N_IRQ(4), .VEC_STRIDE(4), .RESET_PC(0)
    ) dut (
        .clock(clock), .reset(reset), .instr(instr), .pc(pc),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
        .mem_r_data(mem_r_data), .mem_ready(mem_ready),
        .int_req(int_req), .int_mask(int_mask), .int_vec(int_vec),
        .int_ack(int_ack), .in_isr(in_isr), .epc(epc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_r[4];
    logic [7:0]  m_pc, m_epc;
    logic        m_flag, m_isr, m_wait;
    logic [3:0]  s_ack;
    logic        s_we, s_re;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_pc   = '0;
        m_epc  = '0;
        m_flag = 1'b0;
        m_isr  = 1'b0;
        m_wait = 1'b0;
    endtask

    // One clock: drive, check combinational outputs against the model,
    // then advance the model across the edge.
    task automatic cycx(input logic [7:0] ins, input logic rdy,
                        input logic [15:0] rdata, input logic [3:0] req,
                        input logic [3:0] msk, input logic [7:0] vec,
                        input logic rst);
        logic [3:0]  op, pend, e_ack;
        logic [1:0]  rd, rs;
        logic [15:0] a, b;
        logic        take, e_we, e_re;
        int          idx;
        @(negedge clock);
        instr = ins; mem_ready = rdy; mem_r_data = rdata;
        int_req = req; int_mask = msk; int_vec = vec; reset = rst;
        #1;
        op = ins[7:4]; rd = ins[3:2]; rs = ins[1:0];
        a = m_r[rd]; b = m_r[rs];
        pend = req & msk;
        idx = -1;
        for (int i = 0; i < 4; i++)
            if (idx < 0 && pend[i]) idx = i;
        take  = !m_wait && !m_isr && idx >= 0;
        e_ack = take ? 4'(1 << idx) : 4'b0;
        e_re  = !take && (m_wait || op == 4'hE);
        e_we  = !take && !m_wait && op == 4'hF;
        if (rst) begin
            e_ack = '0; e_re = 1'b0; e_we = 1'b0;
        end
        s_ack = int_ack; s_we = mem_w_en; s_re = mem_r_en;
        chk("pc", pc, m_pc);
        chk("epc", epc, m_epc);
        chk("in_isr", in_isr, m_isr);
        chk("int_ack", int_ack, e_ack);
        chk("mem_w_en", mem_w_en, e_we);
        chk("mem_r_en", mem_r_en, e_re);
        chk("mem_addr", mem_addr, b);
        chk("mem_w_data", mem_w_data, a);
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else if (take) begin
            m_epc = m_pc;
            m_pc  = vec + 8'(idx * 4);
            m_isr = 1'b1;
        end else if (m_wait || op == 4'hE) begin
            if (rdy) begin
                m_r[rd] = rdata;
                m_pc    = m_pc + 8'd1;
                m_wait  = 1'b0;
            end else begin
                m_wait = 1'b1;
            end
        end else begin
            m_pc = m_pc + 8'd1;
            case (op)
                4'h0: m_r[rd] = b;
                4'h1: m_r[rd] = a + b;
                4'h2: m_r[rd] = a - b;
                4'h3: m_r[rd] = a & b;
                4'h4: m_r[rd] = a | b;
                4'h5: m_r[rd] = ~b;
                4'h6: m_r[rd] = a << b[3:0];
                4'h7: m_r[rd] = a >> b[3:0];
                4'h8: m_r[rd] = 16'($signed(a) >>> b[3:0]);
                4'h9: m_flag = (a == b);
                4'hA: begin
                    if (m_flag) m_pc = b[7:0];
                    m_flag = 1'b0;
                end
                4'hB: begin
                    if (rd == 2'b11) begin
                        m_pc  = m_epc;
                        m_isr = 1'b0;
                    end else begin
                        m_pc = b[7:0];
                    end
                end
                4'hC: m_r[3][7:4] = ins[3:0];
                4'hD: m_r[3][3:0] = ins[3:0];
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic cyc(input logic [7:0] ins);
        cycx(ins, 1'b1, 16'h0, 4'h0, 4'hF, 8'h80, 1'b0);
    endtask

    task automatic setreg(input logic [1:0] r, input logic [7:0] v);
        cyc({4'hC, v[7:4]});
        cyc({4'hD, v[3:0]});
        if (r != 2'd3) cyc({4'h0, r, 2'd3});
    endtask

    task automatic peek(input logic [1:0] r, output logic [15:0] v);
        instr = {4'h0, 2'd0, r};
        #1;
        v = mem_addr;
    endtask

    logic [15:0] v;
    logic [7:0]  p, ri;

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_reset();

        for (int k = 0; k < 400; k++) begin
            if (!m_wait) ri = 8'($urandom);
            cycx(ri, ($urandom % 4) != 0, 16'($urandom),
                 ($urandom % 6 == 0) ? 4'($urandom) : 4'h0,
                 4'($urandom), 8'($urandom), ($urandom % 97) == 0);
        end

        // Reset in the middle of a stalled load.
        cycx(8'hE4, 1'b0, 16'h0, 4'h0, 4'hF, 8'h80, 1'b0);
        cycx(8'hE4, 1'b0, 16'h0, 4'h0, 4'hF, 8'h80, 1'b1);
        chk("rst_pc", pc, 8'h00);
        chk("rst_isr", in_isr, 1'b0);
        chk("rst_epc", epc, 8'h00);
        cyc(8'hD5);
        chk("rst_r_en", s_re, 1'b0);
        cyc(8'hC3);
        chk("ldi_pc", pc, 8'h02);
        peek(2'd3, v);
        chk("ldi_r3", v, 16'h0035);
        cyc(8'hA3);
        chk("rst_flag", pc, 8'h03);

        // cmp / je taken and not taken.
        setreg(2'd0, 8'h07);
        setreg(2'd1, 8'h07);
        setreg(2'd2, 8'h40);
        cyc(8'h91);
        cyc(8'hA2);
        chk("je_taken", pc, 8'h40);
        setreg(2'd1, 8'h06);
        cyc(8'h91);
        p = pc;
        cyc(8'hA2);
        chk("je_not", pc, p + 8'd1);

        // 16-bit wrap and shifts.
        setreg(2'd1, 8'h01);
        setreg(2'd0, 8'h00);
        cyc(8'h21);
        peek(2'd0, v);
        chk("sub_ffff", v, 16'hFFFF);
        cyc(8'h11);
        peek(2'd0, v);
        chk("add_wrap", v, 16'h0000);
        setreg(2'd2, 8'h01);
        setreg(2'd1, 8'h0F);
        cyc(8'h69);
        peek(2'd2, v);
        chk("sll15", v, 16'h8000);
        cyc(8'h89);
        peek(2'd2, v);
        chk("sra15", v, 16'hFFFF);

        // Load with three stall cycles, then zero-stall load.
        setreg(2'd0, 8'h20);
        p = pc;
        for (int k = 0; k < 3; k++) begin
            cycx(8'hE4, 1'b0, 16'h0, 4'h0, 4'hF, 8'h80, 1'b0);
            chk("ld_stall_ren", s_re, 1'b1);
            chk("ld_stall_pc", pc, p);
        end
        cycx(8'hE4, 1'b1, 16'hBEEF, 4'h0, 4'hF, 8'h80, 1'b0);
        chk("ld_done_ren", s_re, 1'b1);
        chk("ld_done_pc", pc, p + 8'd1);
        peek(2'd1, v);
        chk("ld_data", v, 16'hBEEF);
        cycx(8'hE4, 1'b1, 16'h1234, 4'h0, 4'hF, 8'h80, 1'b0);
        peek(2'd1, v);
        chk("ld_fast", v, 16'h1234);

        // Interrupt entry, no nesting, reti, re-entry.
        setreg(2'd2, 8'h10);
        cyc(8'hB2);
        chk("jmp_pc", pc, 8'h10);
        cycx(8'hF0, 1'b1, 16'h0, 4'b0110, 4'hF, 8'h80, 1'b0);
        chk("irq_ack", s_ack, 4'b0010);
        chk("irq_we", s_we, 1'b0);
        chk("irq_pc", pc, 8'h84);
        chk("irq_epc", epc, 8'h10);
        chk("irq_isr", in_isr, 1'b1);
        cycx(8'h00, 1'b1, 16'h0, 4'b0111, 4'hF, 8'h80, 1'b0);
        chk("nest_ack", s_ack, 4'b0000);
        chk("nest_pc", pc, 8'h85);
        cycx(8'hBC, 1'b1, 16'h0, 4'b0001, 4'hF, 8'h80, 1'b0);
        chk("reti_pc", pc, 8'h10);
        chk("reti_isr", in_isr, 1'b0);
        cycx(8'h00, 1'b1, 16'h0, 4'b0001, 4'hF, 8'h80, 1'b0);
        chk("reirq_ack", s_ack, 4'b0001);
        chk("reirq_pc", pc, 8'h80);

        // pc wraps 0xFF -> 0x00.
        setreg(2'd2, 8'hFF);
        cyc(8'hB2);
        chk("pc_ff", pc, 8'hFF);
        cyc(8'h00);
        chk("pc_wrap", pc, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
